// File: rtl/pedal_pkg.sv
// Shared types and helpers for the pedal-board audio stages.
package pedal_pkg;

  localparam int SAMPLE_W = 16;

  typedef enum logic [1:0] {IDLE, READ, WRITE} echo_state_t;

  // Adds two signed values and clamps to the signed w-bit range (w <= 31).
  function automatic logic signed [31:0] sat_add(input logic signed [31:0] a,
                                                 input logic signed [31:0] b,
                                                 input int w);
    logic signed [32:0] s;
    logic signed [32:0] hi;
    logic signed [32:0] lo;
    s  = {a[31], a} + {b[31], b};
    hi = (33'sd1 <<< (w - 1)) - 33'sd1;
    lo = -(33'sd1 <<< (w - 1));
    if (s > hi)      return hi[31:0];
    else if (s < lo) return lo[31:0];
    else             return s[31:0];
  endfunction

endpackage

// File: rtl/echo_delay_ram.sv
// Single-port delay-line storage with a registered read; maps onto block RAM.
module echo_delay_ram #(
  parameter int DATA_W = 16,
  parameter int DEPTH  = 1024,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk_i,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [DATA_W-1:0] wdata_i,
  output logic [DATA_W-1:0] rdata_o
);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] rdata_q;

  always_ff @(posedge clk_i) begin
    if (we_i) mem_q[addr_i] <= wdata_i;
    rdata_q <= mem_q[addr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/echo_pedal.sv
// Echo/delay effect: circular delay line with saturating feedback and a
// click-free dry/wet crossfade driven by the pedal switch.
module echo_pedal
  import pedal_pkg::*;
#(
  parameter int DATA_W = SAMPLE_W,
  parameter int DEPTH  = 1024,
  parameter int ADDR_W = $clog2(DEPTH),
  parameter int RAMP_W = 4
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              Sample_valid,
  output logic              In_ready,
  input  logic [DATA_W-1:0] Signal_in,
  input  logic              Enable,
  input  logic [ADDR_W-1:0] Delay_len,
  input  logic [2:0]        Feedback_shift,
  output logic [DATA_W-1:0] Signal_out,
  output logic              Out_valid
);

  localparam int EW = DATA_W + 1;
  localparam int PW = DATA_W + RAMP_W + 2;
  localparam logic [ADDR_W:0] FILL_MAX = (ADDR_W + 1)'(DEPTH);
  localparam logic [RAMP_W:0] MIX_MAX  = (RAMP_W + 1)'(1 << RAMP_W);

  echo_state_t state_q, state_d;
  logic [ADDR_W-1:0] wr_ptr_q;
  logic [ADDR_W:0]   fill_q;
  logic [RAMP_W:0]   mix_q;
  logic              out_vld_q;
  logic [DATA_W-1:0] sig_out_q;

  logic signed [DATA_W-1:0] x_p0_q;
  logic                     en_p0_q;
  logic [2:0]               shift_p0_q;
  logic [ADDR_W-1:0]        rd_addr_p0_q;
  logic                     y_zero_p0_q;

  logic              accept;
  logic [ADDR_W-1:0] d_eff;
  logic [DATA_W-1:0] ram_rdata;
  logic              ram_we;
  logic [ADDR_W-1:0] ram_addr;

  assign In_ready = (state_q == IDLE);
  assign accept   = Sample_valid && In_ready;
  assign d_eff    = (Delay_len == '0) ? ADDR_W'(1) : Delay_len;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (Sample_valid) state_d = READ;
      READ:    state_d = WRITE;
      WRITE:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // ---- p0: accept, latch operands and compute the tap address ----
  always_ff @(posedge Clk) begin
    if (accept) begin
      x_p0_q       <= $signed(Signal_in);
      en_p0_q      <= Enable;
      shift_p0_q   <= Feedback_shift;
      rd_addr_p0_q <= wr_ptr_q - d_eff;
      y_zero_p0_q  <= ({1'b0, d_eff} > fill_q);
    end
  end

  // ---- p1: RAM read in READ; the tap is valid during WRITE ----
  assign ram_addr = (state_q == WRITE) ? wr_ptr_q : rd_addr_p0_q;
  assign ram_we   = (state_q == WRITE) && !Reset;

  logic signed [DATA_W-1:0] y_p1, echo_p1;
  logic signed [EW-1:0]     y_ext_p1, fb_p1, echo_ext_p1, x_ext_p1, diff_p1;
  logic [3:0]               shamt_p1;
  logic signed [PW-1:0]     diff_pw_p1, mix_pw_p1, prod_p1, scaled_p1;
  logic signed [31:0]       x_w_p1, fb_w_p1, scaled_w_p1, echo_full_p1, out_full_p1;
  logic                     unused_hi;

  assign y_p1         = y_zero_p0_q ? '0 : $signed(ram_rdata);
  assign y_ext_p1     = y_p1;
  assign shamt_p1     = {1'b0, shift_p0_q} + 4'd1;
  assign fb_p1        = y_ext_p1 >>> shamt_p1;
  assign x_w_p1       = x_p0_q;
  assign fb_w_p1      = fb_p1;
  assign echo_full_p1 = sat_add(x_w_p1, fb_w_p1, DATA_W);
  assign echo_p1      = echo_full_p1[DATA_W-1:0];

  // Crossfade: x + ((echo - x) * mix) / 2**RAMP_W, exact at both ends of the ramp.
  assign echo_ext_p1  = echo_p1;
  assign x_ext_p1     = x_p0_q;
  assign diff_p1      = echo_ext_p1 - x_ext_p1;
  assign diff_pw_p1   = diff_p1;
  assign mix_pw_p1    = {{(PW - RAMP_W - 1){1'b0}}, mix_q};
  assign prod_p1      = diff_pw_p1 * mix_pw_p1;
  assign scaled_p1    = prod_p1 >>> RAMP_W;
  assign scaled_w_p1  = scaled_p1;
  assign out_full_p1  = sat_add(x_w_p1, scaled_w_p1, DATA_W);
  assign unused_hi    = ^{echo_full_p1[31:DATA_W], out_full_p1[31:DATA_W]};

  echo_delay_ram #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_ram (
    .clk_i   (Clk),
    .we_i    (ram_we),
    .addr_i  (ram_addr),
    .wdata_i (echo_p1),
    .rdata_o (ram_rdata)
  );

  // ---- p2: register output, advance pointer, fill and mix ----
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q   <= IDLE;
      wr_ptr_q  <= '0;
      fill_q    <= '0;
      mix_q     <= '0;
      out_vld_q <= 1'b0;
      sig_out_q <= '0;
    end else begin
      state_q   <= state_d;
      out_vld_q <= (state_q == WRITE);
      if (state_q == WRITE) begin
        sig_out_q <= out_full_p1[DATA_W-1:0];
        wr_ptr_q  <= wr_ptr_q + 1'b1;
        if (fill_q != FILL_MAX) fill_q <= fill_q + 1'b1;
        if (en_p0_q && mix_q != MIX_MAX) mix_q <= mix_q + 1'b1;
        else if (!en_p0_q && mix_q != '0) mix_q <= mix_q - 1'b1;
      end
    end
  end

  assign Signal_out = sig_out_q;
  assign Out_valid  = out_vld_q;

endmodule

// File: tb/tb_echo_pedal.sv
// Directed bench for echo_pedal with a 16-entry delay line and a 4-sample ramp.
module tb_echo_pedal;

  logic        Clk = 1'b0;
  logic        Reset = 1'b1;
  logic        Sample_valid = 1'b0;
  logic        In_ready;
  logic [15:0] Signal_in = '0;
  logic        Enable = 1'b0;
  logic [3:0]  Delay_len = '0;
  logic [2:0]  Feedback_shift = '0;
  logic [15:0] Signal_out;
  logic        Out_valid;

  int checks = 0;
  int failures = 0;

  echo_pedal #(
    .DATA_W (16),
    .DEPTH  (16),
    .ADDR_W (4),
    .RAMP_W (2)
  ) dut (
    .Clk            (Clk),
    .Reset          (Reset),
    .Sample_valid   (Sample_valid),
    .In_ready       (In_ready),
    .Signal_in      (Signal_in),
    .Enable         (Enable),
    .Delay_len      (Delay_len),
    .Feedback_shift (Feedback_shift),
    .Signal_out     (Signal_out),
    .Out_valid      (Out_valid)
  );

  always #5 Clk = ~Clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1);
  end

  task automatic do_reset();
    Reset = 1'b1;
    Sample_valid = 1'b0;
    @(posedge Clk);
    @(posedge Clk);
    #1;
    Reset = 1'b0;
  endtask

  // Offers one sample, waits for its Out_valid and returns the output.
  task automatic send(input logic [15:0] x, output logic [15:0] y);
    int  n;
    bit  got;
    n = 0;
    while (!In_ready && n < 10) begin
      @(posedge Clk);
      #1;
      n++;
    end
    Signal_in = x;
    Sample_valid = 1'b1;
    @(posedge Clk);
    #1;
    Sample_valid = 1'b0;
    n = 0;
    got = 1'b0;
    while (!got && n < 6) begin
      @(posedge Clk);
      #1;
      n++;
      if (Out_valid) got = 1'b1;
    end
    checks++;
    if (!got || n != 2) begin
      failures++;
      $display("FAIL out_valid_latency got=%0d cycles (seen=%0d) exp=2", n, got);
    end
    y = Signal_out;
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if (In_ready !== 1'b1) begin
      failures++; $display("FAIL reset_in_ready got=%b exp=1", In_ready);
    end
    checks++;
    if (Out_valid !== 1'b0) begin
      failures++; $display("FAIL reset_out_valid got=%b exp=0", Out_valid);
    end
    checks++;
    if (Signal_out !== 16'h0000) begin
      failures++; $display("FAIL reset_signal_out got=%h exp=0000", Signal_out);
    end
  endtask

  task automatic test_bypass();
    logic [15:0] y;
    Enable = 1'b0; Delay_len = 4'd0; Feedback_shift = 3'd0;
    send(16'h4af3, y);
    checks++;
    if (y !== 16'h4af3) begin
      failures++; $display("FAIL bypass got=%h exp=4af3", y);
    end
  endtask

  task automatic test_impulse();
    logic [15:0] y;
    logic [15:0] exp_v [9] = '{16'h4000, 16'h0000, 16'h0000, 16'h0000, 16'h2000,
                               16'h0000, 16'h0000, 16'h0000, 16'h1000};
    do_reset();
    Enable = 1'b1; Delay_len = 4'd4; Feedback_shift = 3'd0;
    for (int i = 0; i < 4; i++) send(16'h0000, y);
    for (int i = 0; i < 9; i++) begin
      send((i == 0) ? 16'h4000 : 16'h0000, y);
      checks++;
      if (y !== exp_v[i]) begin
        failures++; $display("FAIL impulse[%0d] got=%h exp=%h", i, y, exp_v[i]);
      end
    end
  endtask

  task automatic test_saturation(input logic [15:0] x, input logic [15:0] hold);
    logic [15:0] y;
    do_reset();
    Enable = 1'b1; Delay_len = 4'd1; Feedback_shift = 3'd0;
    for (int i = 0; i < 4; i++) send(16'h0000, y);
    send(x, y);
    checks++;
    if (y !== x) begin
      failures++; $display("FAIL sat_first got=%h exp=%h", y, x);
    end
    for (int i = 0; i < 11; i++) begin
      send(x, y);
      checks++;
      if (y !== hold) begin
        failures++; $display("FAIL sat_hold[%0d] got=%h exp=%h", i, y, hold);
      end
    end
  endtask

  // Stale RAM from the previous test must stay silent until the line has filled.
  task automatic test_fill_wrap();
    logic [15:0] y;
    logic [15:0] e;
    do_reset();
    Enable = 1'b1; Delay_len = 4'd8; Feedback_shift = 3'd0;
    for (int i = 0; i < 40; i++) begin
      send((i == 0) ? 16'h4000 : 16'h0000, y);
      case (i)
        0:       e = 16'h4000;
        8:       e = 16'h2000;
        16:      e = 16'h1000;
        24:      e = 16'h0800;
        32:      e = 16'h0400;
        default: e = 16'h0000;
      endcase
      checks++;
      if (y !== e) begin
        failures++; $display("FAIL fill_wrap[%0d] got=%h exp=%h", i, y, e);
      end
    end
  endtask

  task automatic test_crossfade();
    logic [15:0] y;
    logic [15:0] exp_v [7] = '{16'h0800, 16'h0c00, 16'h1000, 16'h1400, 16'h1800,
                               16'h1400, 16'h1100};
    do_reset();
    Enable = 1'b0; Delay_len = 4'd5; Feedback_shift = 3'd0;
    for (int i = 0; i < 5; i++) begin
      send(16'h2000, y);
      checks++;
      if (y !== 16'h2000) begin
        failures++; $display("FAIL xfade_prefill[%0d] got=%h exp=2000", i, y);
      end
    end
    for (int i = 0; i < 7; i++) begin
      Enable = (i < 5);
      send(16'h0800, y);
      checks++;
      if (y !== exp_v[i]) begin
        failures++; $display("FAIL xfade[%0d] got=%h exp=%h", i, y, exp_v[i]);
      end
    end
  endtask

  task automatic test_back_to_back();
    int          cnt;
    logic [15:0] val;
    do_reset();
    Enable = 1'b0; Delay_len = 4'd0; Feedback_shift = 3'd0;
    Signal_in = 16'h1111;
    Sample_valid = 1'b1;
    @(posedge Clk);
    #1;
    checks++;
    if (In_ready !== 1'b0) begin
      failures++; $display("FAIL b2b_in_ready got=%b exp=0", In_ready);
    end
    Signal_in = 16'h2222;
    @(posedge Clk);
    #1;
    Sample_valid = 1'b0;
    cnt = 0;
    val = '0;
    for (int i = 0; i < 8; i++) begin
      if (Out_valid) begin cnt++; val = Signal_out; end
      @(posedge Clk);
      #1;
    end
    checks++;
    if (cnt != 1) begin
      failures++; $display("FAIL b2b_pulses got=%0d exp=1", cnt);
    end
    checks++;
    if (val !== 16'h1111) begin
      failures++; $display("FAIL b2b_value got=%h exp=1111", val);
    end
  endtask

  // Reset landing in READ or in WRITE must drop the sample without touching RAM.
  task automatic test_reset_midop(input int wait_cycles);
    logic [15:0] y;
    int          cnt;
    do_reset();
    Enable = 1'b0; Delay_len = 4'd0; Feedback_shift = 3'd0;
    send(16'h1234, y);
    checks++;
    if (y !== 16'h1234) begin
      failures++; $display("FAIL midop_seed got=%h exp=1234", y);
    end
    do_reset();
    Signal_in = 16'h5555;
    Sample_valid = 1'b1;
    @(posedge Clk);
    #1;
    Sample_valid = 1'b0;
    for (int i = 0; i < wait_cycles; i++) begin
      @(posedge Clk);
      #1;
    end
    Reset = 1'b1;
    @(posedge Clk);
    #1;
    Reset = 1'b0;
    checks++;
    if (In_ready !== 1'b1) begin
      failures++; $display("FAIL midop_in_ready[%0d] got=%b exp=1", wait_cycles, In_ready);
    end
    cnt = 0;
    for (int i = 0; i < 6; i++) begin
      if (Out_valid) cnt++;
      @(posedge Clk);
      #1;
    end
    checks++;
    if (cnt != 0) begin
      failures++; $display("FAIL midop_out_valid[%0d] got=%0d exp=0", wait_cycles, cnt);
    end
    checks++;
    if (dut.u_ram.mem_q[0] !== 16'h1234) begin
      failures++;
      $display("FAIL midop_ram[%0d] got=%h exp=1234", wait_cycles, dut.u_ram.mem_q[0]);
    end
  endtask

  initial begin
    test_reset();
    test_bypass();
    test_impulse();
    test_saturation(16'h7000, 16'h7fff);
    test_saturation(16'h9000, 16'h8000);
    test_fill_wrap();
    test_crossfade();
    test_back_to_back();
    test_reset_midop(0);
    test_reset_midop(1);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
